unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
- Shares one single-port synchronous RAM between three requesters: processor instruction fetch (IF), processor data access (ME), and the UART host loader/debugger (HOST).
- Sits between the processor's fetch and memory ports and the shared RAM.
- Sequences every access as grant then response.
- Generates the IF and ME stall signals.
- Holds processor traffic off while the host owns memory.

Parameters:
ADDR_WIDTH, 12, word-address width driven to RAM (byte address bits [ADDR_WIDTH+1:2])
DATA_WIDTH, 32, data word width
STARVE_LIMIT, 4, max consecutive ME grants while IF waits before IF is forced

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request, held until if_ready
if_addr  in  32  fetch byte address
if_rdata  out  DATA_WIDTH  fetched instruction
if_ready  out  1  one-cycle pulse: if_rdata valid
if_stall  out  1  if_req & ~if_ready
me_read  in  1  data read request
me_write  in  1  data write request
me_addr  in  32  data byte address
me_wdata  in  DATA_WIDTH  store data
me_rdata  out  DATA_WIDTH  load data
me_ready  out  1  one-cycle pulse: access complete
me_stall  out  1  (me_read|me_write) & ~me_ready
me_error  out  1  one-cycle pulse: misaligned address or read+write together
host_hold  in  1  host owns memory; IF/ME not granted
host_req  in  1  host access request
host_we  in  1  host write
host_addr  in  32  host byte address
host_wdata  in  DATA_WIDTH  host write data
host_rdata  out  DATA_WIDTH  host read data
host_ack  out  1  one-cycle pulse: host access complete
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=NONE, starve_cnt=0, held read registers=0. All outputs 0 immediately; mem_en drops in the same instant. Any in-flight access is discarded with no ready or ack.

FSM states: IDLE, RESP.

- IDLE, cycle N: pick a winner, drive mem_en=1, mem_addr=addr[ADDR_WIDTH+1:2], mem_we, mem_wdata; register owner; go to RESP. No request: stay IDLE, mem_en=0.
- RESP, cycle N+1:
  - Owner's ready/ack=1.
  - Owner's rdata = mem_rdata for reads, also captured into that owner's held register.
  - Other requesters' rdata outputs show their held registers.
  - Writes also pulse ready in RESP.
  - Return to IDLE.
  - One access every 2 cycles maximum; latency is fixed at 2 cycles from request seen in IDLE.

Winner selection in IDLE:
- host_hold=1: HOST if host_req, else none. IF and ME are never granted.
- host_hold=0: ME if (me_read|me_write) and (starve_cnt<STARVE_LIMIT or ~if_req); else IF if if_req. host_req is ignored.
- starve_cnt: +1 on each ME grant while if_req=1 (saturates); cleared on IF grant. Holds its value across host_hold periods.

Boundary cases:
- me_read & me_write both set: performed as write; me_error pulses in RESP.
- me_addr[1:0]!=0: access performed at truncated word address; me_error pulses in RESP. IF/HOST misalignment is silently truncated.
- Requester drops its request during RESP: ready still pulses; response data is still driven.
- host_hold rises while RESP owned by IF/ME: that response completes normally; HOST arbitration starts at next IDLE.
- Stall outputs are combinational from the request inputs and ready.

Decomposition:
- Shared constants header (alongside the existing constants file):
  - owner encoding OWN_NONE=0, OWN_IF=1, OWN_ME=2, OWN_HOST=3
  - state encoding ST_IDLE=0, ST_RESP=1
- Sub-module arbiter_grant_select: combinational winner picker taking requests, host_hold and starve_cnt, returning the owner code. Unit-testable alone.

Test Plan:
- IF only, if_addr=0x10, RAM[4]=0x2008000A -> mem_en in N with mem_addr=4; if_ready pulse in N+1 with if_rdata=0x2008000A; if_stall=1 in N only.
- ME write me_addr=0x20 data=0xDEADBEEF, then ME read same address -> mem_we=1, mem_addr=8; me_ready pulses twice; second me_rdata=0xDEADBEEF.
- if_req and me_read held continuously, STARVE_LIMIT=4 -> grant order ME,ME,ME,ME,IF repeating; if_ready every 10th cycle.
- host_hold=1 with if_req, host write 0x00000001 to 0x0 -> no IF grant; host_ack in N+1. host_hold=0 -> IF granted next IDLE, reads 0x00000001.
- me_addr=0x22 read, and separately me_read=me_write=1 -> me_error pulses with me_ready; both accesses complete at word address 8 (second as write).
- reset low during RESP -> all outputs 0 immediately; no ready pulse; after release, first request granted from IDLE.

Source files
------------

// File: rtl/unified_memory_arbiter_pkg.sv
// unified_memory_arbiter_pkg: owner and state encodings shared by the arbiter and its grant picker.
package unified_memory_arbiter_pkg;
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_ME   = 2'd2,
      OWN_HOST = 2'd3
   } owner_t;
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;
endpackage

// File: rtl/arbiter_grant_select.sv
// arbiter_grant_select: picks which requester gets the RAM this cycle.
module arbiter_grant_select
   import unified_memory_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic             if_req,
   input  logic             me_req,
   input  logic             host_req,
   input  logic             host_hold,
   input  logic [CNT_W-1:0] starve_cnt,
   output owner_t           owner
);
   logic me_ok;
   assign me_ok = me_req && (starve_cnt < CNT_W'(STARVE_LIMIT) || !if_req);
   always_comb begin
      owner = OWN_NONE;
      if (host_hold) owner = host_req ? OWN_HOST : OWN_NONE;
      else if (me_ok) owner = OWN_ME;
      else if (if_req) owner = OWN_IF;
   end
endmodule

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one single-port RAM between fetch, data and host ports.
module unified_memory_arbiter
   import unified_memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ready,
   output logic                  if_stall,
   input  logic                  me_read,
   input  logic                  me_write,
   input  logic [31:0]           me_addr,
   input  logic [DATA_WIDTH-1:0] me_wdata,
   output logic [DATA_WIDTH-1:0] me_rdata,
   output logic                  me_ready,
   output logic                  me_stall,
   output logic                  me_error,
   input  logic                  host_hold,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [31:0]           host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  host_ack,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   state_t                state;
   owner_t                owner, winner;
   logic                  owner_we, err_q, me_req, go, resp;
   logic [CW-1:0]         starve_cnt;
   logic [31:0]           sel_addr;
   logic [DATA_WIDTH-1:0] if_held, me_held, host_held;
   logic                  unused;

   assign me_req = me_read | me_write;
   assign unused = &{1'b0, if_addr[31:ADDR_WIDTH+2], if_addr[1:0], me_addr[31:ADDR_WIDTH+2],
                     host_addr[31:ADDR_WIDTH+2], host_addr[1:0]};

   arbiter_grant_select #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CW)) u_sel (
      .if_req    (if_req),
      .me_req    (me_req),
      .host_req  (host_req),
      .host_hold (host_hold),
      .starve_cnt(starve_cnt),
      .owner     (winner)
   );

   // Gating with reset makes the RAM port and stalls drop in the same instant reset asserts.
   assign go       = reset && state == ST_IDLE && winner != OWN_NONE;
   assign resp     = state == ST_RESP;
   assign sel_addr = winner == OWN_IF ? if_addr : winner == OWN_ME ? me_addr : host_addr;

   always_comb begin
      mem_en    = go;
      mem_addr  = go ? sel_addr[ADDR_WIDTH+1:2] : '0;
      mem_we    = go && (winner == OWN_ME ? me_write : winner == OWN_HOST && host_we);
      mem_wdata = !go ? '0 : winner == OWN_ME ? me_wdata : winner == OWN_HOST ? host_wdata : '0;
   end

   assign if_ready   = resp && owner == OWN_IF;
   assign me_ready   = resp && owner == OWN_ME;
   assign host_ack   = resp && owner == OWN_HOST;
   assign me_error   = me_ready && err_q;
   assign if_stall   = reset && if_req && !if_ready;
   assign me_stall   = reset && me_req && !me_ready;
   assign if_rdata   = if_ready && !owner_we ? mem_rdata : if_held;
   assign me_rdata   = me_ready && !owner_we ? mem_rdata : me_held;
   assign host_rdata = host_ack && !owner_we ? mem_rdata : host_held;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         owner_we   <= 1'b0;
         err_q      <= 1'b0;
         starve_cnt <= '0;
         if_held    <= '0;
         me_held    <= '0;
         host_held  <= '0;
      end else if (state == ST_IDLE) begin
         if (go) begin
            state    <= ST_RESP;
            owner    <= winner;
            owner_we <= mem_we;
            err_q    <= winner == OWN_ME && ((me_read && me_write) || me_addr[1:0] != 2'b00);
            if (winner == OWN_IF) starve_cnt <= '0;
            else if (winner == OWN_ME && if_req && starve_cnt < CW'(STARVE_LIMIT))
               starve_cnt <= starve_cnt + 1'b1;
         end
      end else begin
         state <= ST_IDLE;
         owner <= OWN_NONE;
         if (!owner_we && owner == OWN_IF) if_held <= mem_rdata;
         if (!owner_we && owner == OWN_ME) me_held <= mem_rdata;
         if (!owner_we && owner == OWN_HOST) host_held <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb_unified_memory_arbiter: directed checks of arbitration, latency, errors and reset.
module tb_unified_memory_arbiter;
   logic        clock = 1'b0, reset = 1'b0;
   logic        if_req = 0, me_read = 0, me_write = 0, host_hold = 0, host_req = 0, host_we = 0;
   logic [31:0] if_addr = 0, me_addr = 0, me_wdata = 0, host_addr = 0, host_wdata = 0;
   logic [31:0] if_rdata, me_rdata, host_rdata, mem_wdata, mem_rdata;
   logic        if_ready, if_stall, me_ready, me_stall, me_error, host_ack, mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] ram [0:4095];
   int          n_tests = 0, n_fail = 0;

   unified_memory_arbiter dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
      .me_read(me_read), .me_write(me_write), .me_addr(me_addr), .me_wdata(me_wdata),
      .me_rdata(me_rdata), .me_ready(me_ready), .me_stall(me_stall), .me_error(me_error),
      .host_hold(host_hold), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
      ram[4] = 32'h2008000A;
      mem_rdata = 32'h0;
      if_req = 1'b1;
      #12;
      check("rst_mem_en", {31'b0, mem_en}, 0);
      check("rst_if_stall", {31'b0, if_stall}, 0);
      check("rst_readies", {29'b0, if_ready, me_ready, host_ack}, 0);
      check("rst_if_rdata", if_rdata, 0);
      if_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      // IF fetch
      @(negedge clock);
      if_req = 1; if_addr = 32'h10;
      #1;
      check("if_mem_en", {31'b0, mem_en}, 1);
      check("if_mem_addr", {20'b0, mem_addr}, 4);
      check("if_stall_n", {31'b0, if_stall}, 1);
      @(negedge clock);
      check("if_ready", {31'b0, if_ready}, 1);
      check("if_rdata", if_rdata, 32'h2008000A);
      check("if_stall_n1", {31'b0, if_stall}, 0);
      if_req = 0;
      @(negedge clock);
      check("if_ready_low", {31'b0, if_ready}, 0);
      check("if_rdata_held", if_rdata, 32'h2008000A);

      // ME write then read
      me_write = 1; me_addr = 32'h20; me_wdata = 32'hDEADBEEF;
      #1;
      check("mw_we", {31'b0, mem_we}, 1);
      check("mw_addr", {20'b0, mem_addr}, 8);
      check("mw_wdata", mem_wdata, 32'hDEADBEEF);
      @(negedge clock);
      check("mw_ready", {30'b0, me_ready, me_error}, 2'b10);
      me_write = 0;
      @(negedge clock);
      me_read = 1;
      #1;
      check("mr_en_we", {30'b0, mem_en, mem_we}, 2'b10);
      @(negedge clock);
      check("mr_ready", {31'b0, me_ready}, 1);
      check("mr_rdata", me_rdata, 32'hDEADBEEF);
      me_read = 0;

      // Starvation: ME,ME,ME,ME,IF repeating
      @(negedge clock);
      if_req = 1; me_read = 1;
      for (int k = 1; k < 20; k++) begin
         @(negedge clock);
         if (k % 2 == 1) check($sformatf("starve_k%0d", k), {30'b0, if_ready, me_ready},
                               ((k - 1) / 2) % 5 == 4 ? 32'd2 : 32'd1);
      end
      if_req = 0; me_read = 0;

      // Host owns memory while IF waits
      @(negedge clock);
      host_hold = 1; if_req = 1; if_addr = 0; host_req = 1; host_we = 1; host_addr = 0; host_wdata = 1;
      #1;
      check("host_mem", {20'b0, mem_addr, 1'b0, mem_en, mem_we}, {20'b0, 12'd0, 3'b011});
      @(negedge clock);
      check("host_ack", {30'b0, host_ack, if_ready}, 2'b10);
      host_req = 0;
      @(negedge clock);
      check("host_block_if", {31'b0, mem_en}, 0);
      host_hold = 0;
      #1;
      check("if_after_host_en", {31'b0, mem_en}, 1);
      @(negedge clock);
      check("if_after_host_rdy", {31'b0, if_ready}, 1);
      check("if_after_host_data", if_rdata, 32'h1);
      if_req = 0;

      // Misaligned read, then read+write conflict
      @(negedge clock);
      me_read = 1; me_addr = 32'h22;
      #1;
      check("mis_addr", {20'b0, mem_addr}, 8);
      @(negedge clock);
      check("mis_err", {30'b0, me_ready, me_error}, 2'b11);
      check("mis_rdata", me_rdata, 32'hDEADBEEF);
      me_read = 0;
      @(negedge clock);
      me_read = 1; me_write = 1; me_addr = 32'h20; me_wdata = 32'h12345678;
      #1;
      check("rw_mem", {19'b0, mem_addr, mem_we}, {19'b0, 12'd8, 1'b1});
      @(negedge clock);
      check("rw_err", {30'b0, me_ready, me_error}, 2'b11);
      me_read = 0; me_write = 0;
      @(negedge clock);
      check("rw_err_low", {31'b0, me_error}, 0);
      check("rw_ram", ram[8], 32'h12345678);

      // Reset during RESP
      if_req = 1; if_addr = 32'h10;
      @(negedge clock);
      reset = 0;
      #1;
      check("rr_ready", {31'b0, if_ready}, 0);
      check("rr_out", {29'b0, mem_en, if_stall, me_stall}, 0);
      check("rr_rdata", if_rdata, 0);
      @(negedge clock);
      reset = 1;
      #1;
      check("rr_regrant", {19'b0, mem_addr, mem_en}, {19'b0, 12'd4, 1'b1});
      @(negedge clock);
      check("rr_if_rdata", if_rdata, 32'h2008000A);
      if_req = 0;
      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
